register_file_sb: RTL and testbench

- Parametrised successor to the core register file, adding configurable width and depth, a hard-wired zero register, write-to-read bypass, and a per-register busy scoreboard for pipelined hazard detection.
- Sits between decode/issue (reads, reservations) and writeback (writes).
- Decode uses the busy outputs to stall on RAW hazards. Writeback clears busy bits as results retire.

---
 rtl/register_file_sb.sv | 123 ++++++++++++
 tb/tb_register_file_sb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// register_file_sb: parametrised register file with a hard-wired zero register,
// write-to-read bypass and a per-register busy scoreboard for RAW hazard detection.
//
// Ports:
//   clk, reset_n              rising-edge clock, synchronous active-low reset
//   read_addr_1/2             read port addresses
//   read_data_1/2             read port data (combinational)
//   read_busy_1/2             addressed register awaits a pending write (combinational)
//   reg_write, write_addr,
//   write_data                writeback port; a write clears the busy bit
//   rsv_en, rsv_addr          issue-side reservation; marks a register busy
//   busy_count                registered number of busy registers
module register_file_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] read_addr_1,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              read_busy_1,
    output logic              read_busy_2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   busy_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic [CNT_W-1:0]  count_next;
    logic              wr_ok;
    logic              rsv_ok;
    logic              zero_rd_1;
    logic              zero_rd_2;

    // Qualified write/reserve: dropped during reset and on the zero register.
    // Gating the write with reset_n also keeps the bypass quiet while in reset,
    // so reads then show the stored array contents.
    assign wr_ok  = reset_n && reg_write
                    && !((ZERO_REG != 0) && (write_addr == '0));
    assign rsv_ok = reset_n && rsv_en
                    && !((ZERO_REG != 0) && (rsv_addr == '0));

    assign zero_rd_1 = (ZERO_REG != 0) && (read_addr_1 == '0);
    assign zero_rd_2 = (ZERO_REG != 0) && (read_addr_2 == '0);

    // Busy update: write clears, reservation sets; reservation applied last so a
    // same-address reserve (newer producer) wins over the retiring write.
    always_comb begin : busy_update
        busy_next = busy;
        if (wr_ok) begin
            busy_next[write_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_next[rsv_addr] = 1'b1;
        end
    end

    // Popcount of the post-update busy vector.
    always_comb begin : busy_popcount
        count_next = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_next = count_next + CNT_W'(busy_next[i]);
        end
    end

    // State: register array, busy vector and busy count.
    always_ff @(posedge clk) begin : state_reg
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wr_ok) begin
                regs[write_addr] <= write_data;
            end
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    // Read port 1: array read, optional bypass, zero-register override last.
    always_comb begin : read_port_1
        read_data_1 = regs[read_addr_1];
        read_busy_1 = busy[read_addr_1];
        if ((BYPASS != 0) && wr_ok && (write_addr == read_addr_1)) begin
            read_data_1 = write_data;
            read_busy_1 = 1'b0;
        end
        if (zero_rd_1) begin
            read_data_1 = '0;
            read_busy_1 = 1'b0;
        end
    end

    // Read port 2: identical to port 1.
    always_comb begin : read_port_2
        read_data_2 = regs[read_addr_2];
        read_busy_2 = busy[read_addr_2];
        if ((BYPASS != 0) && wr_ok && (write_addr == read_addr_2)) begin
            read_data_2 = write_data;
            read_busy_2 = 1'b0;
        end
        if (zero_rd_2) begin
            read_data_2 = '0;
            read_busy_2 = 1'b0;
        end
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Scoreboard bench for register_file_sb: directed stimulus pushes hand-computed
// expectations tagged with the cycle they apply to; a monitor on the falling
// edge pops and compares them. A second instance with BYPASS=0 shares inputs.
module tb_register_file_sb;

    typedef enum int {K_D1, K_B1, K_D2, K_B2, K_CNT,
                      K_ND1, K_NB1, K_ND2, K_NB2, K_NCNT} kind_t;

    typedef struct {
        int          cyc;
        string       name;
        kind_t       kind;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [4:0]  read_addr_1;
    logic [4:0]  read_addr_2;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic        read_busy_1;
    logic        read_busy_2;
    logic [5:0]  busy_count;

    logic [31:0] nb_read_data_1;
    logic [31:0] nb_read_data_2;
    logic        nb_read_busy_1;
    logic        nb_read_busy_2;
    logic [5:0]  nb_busy_count;

    exp_t        q[$];
    exp_t        it;
    logic [31:0] act;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    register_file_sb dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .read_addr_1(read_addr_1),
        .read_addr_2(read_addr_2),
        .read_data_1(read_data_1),
        .read_data_2(read_data_2),
        .read_busy_1(read_busy_1),
        .read_busy_2(read_busy_2),
        .reg_write  (reg_write),
        .write_addr (write_addr),
        .write_data (write_data),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .busy_count (busy_count)
    );

    register_file_sb #(.BYPASS(0)) dut_nb (
        .clk        (clk),
        .reset_n    (reset_n),
        .read_addr_1(read_addr_1),
        .read_addr_2(read_addr_2),
        .read_data_1(nb_read_data_1),
        .read_data_2(nb_read_data_2),
        .read_busy_1(nb_read_busy_1),
        .read_busy_2(nb_read_busy_2),
        .reg_write  (reg_write),
        .write_addr (write_addr),
        .write_data (write_data),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .busy_count (nb_busy_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            it = q.pop_front();
            case (it.kind)
                K_D1:    act = read_data_1;
                K_B1:    act = 32'(read_busy_1);
                K_D2:    act = read_data_2;
                K_B2:    act = 32'(read_busy_2);
                K_CNT:   act = 32'(busy_count);
                K_ND1:   act = nb_read_data_1;
                K_NB1:   act = 32'(nb_read_busy_1);
                K_ND2:   act = nb_read_data_2;
                K_NB2:   act = 32'(nb_read_busy_2);
                default: act = 32'(nb_busy_count);
            endcase
            checks++;
            if (act !== it.val) begin
                errors++;
                $display("FAIL %s (%s) cycle %0d: got %h expected %h",
                         it.name, it.kind.name(), cyc, act, it.val);
            end
        end
    end

    task automatic ex(input string n, input kind_t k, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.name = n;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write = 1'b0;
        rsv_en    = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        reg_write  = 1'b1;
        write_addr = a;
        write_data = d;
    endtask

    task automatic do_rsv(input logic [4:0] a);
        rsv_en   = 1'b1;
        rsv_addr = a;
    endtask

    initial begin
        reset_n     = 1'b0;
        read_addr_1 = '0;
        read_addr_2 = '0;
        reg_write   = 1'b0;
        write_addr  = '0;
        write_data  = '0;
        rsv_en      = 1'b0;
        rsv_addr    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 1. Reset state across all addresses, then write/read r7.
        for (int a = 0; a < 32; a++) begin
            read_addr_1 = 5'(a);
            read_addr_2 = 5'(a);
            ex("rst_d1", K_D1, 32'h0);
            ex("rst_b1", K_B1, 32'h0);
            ex("rst_d2", K_D2, 32'h0);
            ex("rst_b2", K_B2, 32'h0);
            ex("rst_nd1", K_ND1, 32'h0);
            ex("rst_nb1", K_NB1, 32'h0);
            ex("rst_nb2", K_NB2, 32'h0);
            if (a == 0) begin
                ex("rst_cnt", K_CNT, 32'h0);
                ex("rst_ncnt", K_NCNT, 32'h0);
            end
            tick();
        end
        do_write(5'd7, 32'h0000_00A5);
        tick();
        idle();
        read_addr_1 = 5'd7;
        read_addr_2 = 5'd7;
        ex("r7_rd", K_D1, 32'h0000_00A5);
        ex("r7_nb_rd", K_ND2, 32'h0000_00A5);
        tick();

        // 2. Zero register ignores writes and reservations.
        do_write(5'd0, 32'hFFFF_FFFF);
        do_rsv(5'd0);
        read_addr_1 = 5'd0;
        read_addr_2 = 5'd0;
        ex("z_d1", K_D1, 32'h0);
        ex("z_b1", K_B1, 32'h0);
        ex("z_d2", K_D2, 32'h0);
        ex("z_nd2", K_ND2, 32'h0);
        ex("z_cnt", K_CNT, 32'h0);
        tick();
        idle();
        ex("z_d1_next", K_D1, 32'h0);
        ex("z_b1_next", K_B1, 32'h0);
        ex("z_cnt_next", K_CNT, 32'h0);
        tick();

        // 3. Bypass vs. no bypass.
        do_write(5'd5, 32'h1234_5678);
        read_addr_2 = 5'd5;
        ex("byp_d2", K_D2, 32'h1234_5678);
        ex("byp_b2", K_B2, 32'h0);
        ex("nobyp_d2", K_ND2, 32'h0);
        tick();
        idle();
        ex("byp_d2_next", K_D2, 32'h1234_5678);
        ex("nobyp_d2_next", K_ND2, 32'h1234_5678);
        tick();

        // 4. RAW scoreboard on r9.
        do_rsv(5'd9);
        read_addr_1 = 5'd9;
        ex("r9_b_rsvcyc", K_B1, 32'h0);
        ex("r9_cnt_rsvcyc", K_CNT, 32'h0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            ex("r9_busy", K_B1, 32'h1);
            ex("r9_cnt1", K_CNT, 32'h1);
            tick();
        end
        do_write(5'd9, 32'd42);
        read_addr_2 = 5'd9;
        ex("r9_byp_d1", K_D1, 32'd42);
        ex("r9_byp_b1", K_B1, 32'h0);
        ex("r9_byp_d2", K_D2, 32'd42);
        ex("r9_byp_b2", K_B2, 32'h0);
        ex("r9_nobyp_d2", K_ND2, 32'h0);
        ex("r9_nobyp_b2", K_NB2, 32'h1);
        ex("r9_cnt_wcyc", K_CNT, 32'h1);
        tick();
        idle();
        ex("r9_d_after", K_D1, 32'd42);
        ex("r9_b_after", K_B1, 32'h0);
        ex("r9_cnt_after", K_CNT, 32'h0);
        tick();

        // 5. Same-address reserve+write, and different-address reserve+write.
        do_rsv(5'd3);
        tick();
        do_rsv(5'd6);
        tick();
        idle();
        do_write(5'd3, 32'hDEAD_BEEF);
        do_rsv(5'd3);
        read_addr_1 = 5'd3;
        ex("r3_cnt_pre", K_CNT, 32'd2);
        ex("r3_byp_d1", K_D1, 32'hDEAD_BEEF);
        ex("r3_byp_b1", K_B1, 32'h0);
        tick();
        idle();
        ex("r3_d", K_D1, 32'hDEAD_BEEF);
        ex("r3_b_rsv_wins", K_B1, 32'h1);
        ex("r3_cnt", K_CNT, 32'd2);
        tick();
        do_rsv(5'd4);
        do_write(5'd6, 32'h66);
        read_addr_1 = 5'd4;
        read_addr_2 = 5'd6;
        ex("r4_b_rsvcyc", K_B1, 32'h0);
        ex("r6_byp_b2", K_B2, 32'h0);
        ex("r6_byp_d2", K_D2, 32'h66);
        ex("r46_cnt_pre", K_CNT, 32'd2);
        tick();
        idle();
        ex("r4_b", K_B1, 32'h1);
        ex("r6_b", K_B2, 32'h0);
        ex("r6_d", K_D2, 32'h66);
        ex("r46_cnt", K_CNT, 32'd2);
        tick();

        // 6. Clear r3/r4, build three reservations, then reset mid-operation.
        do_write(5'd3, 32'hDEAD_BEEF);
        tick();
        do_write(5'd4, 32'h0);
        tick();
        idle();
        ex("clr_cnt", K_CNT, 32'h0);
        do_rsv(5'd1);
        tick();
        do_rsv(5'd2);
        tick();
        do_rsv(5'd10);
        tick();
        idle();
        ex("three_cnt", K_CNT, 32'd3);
        do_write(5'd2, 32'd7);
        tick();
        reset_n = 1'b0;
        do_write(5'd11, 32'd99);
        read_addr_1 = 5'd2;
        read_addr_2 = 5'd11;
        ex("inrst_d1", K_D1, 32'd7);
        ex("inrst_b1", K_B1, 32'h0);
        ex("inrst_d2_nobyp", K_D2, 32'h0);
        ex("inrst_cnt", K_CNT, 32'd2);
        tick();
        reset_n = 1'b1;
        idle();
        ex("postrst_r2", K_D1, 32'h0);
        ex("postrst_r11", K_D2, 32'h0);
        ex("postrst_cnt", K_CNT, 32'h0);
        tick();
        read_addr_1 = 5'd1;
        read_addr_2 = 5'd10;
        ex("postrst_b1", K_B1, 32'h0);
        ex("postrst_b10", K_B2, 32'h0);
        tick();
        read_addr_1 = 5'd7;
        read_addr_2 = 5'd9;
        ex("postrst_r7", K_D1, 32'h0);
        ex("postrst_r9", K_D2, 32'h0);
        tick();

        // Drain scoreboard with a bounded wait.
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
